// File: rtl/complete_stage_pkg.sv
// ============================================================================
// complete_stage_pkg : shared types and sizing for the COMPLETE/ROB stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package complete_stage_pkg;

  localparam int ROB_DEPTH  = 16;
  localparam int DISPATCH_W = 2;
  localparam int NUM_FU     = 3;

  localparam int TAG_W     = $clog2(ROB_DEPTH);
  localparam int CNT_W     = TAG_W + 1;
  localparam int RET_CNT_W = $clog2(DISPATCH_W + 1);

  typedef logic [31:0]      word;
  typedef logic [6:0]       p_reg;
  typedef logic [TAG_W-1:0] rob_tag_t;
  typedef logic [CNT_W-1:0] rob_cnt_t;

  typedef struct packed {
    logic     valid;
    rob_tag_t rob_tag;
    p_reg     PRegAddrDst;
    word      data;
    logic     RegWrite;
    logic     MemWrite;
    logic     complete;
  } rob_row_struct;

  typedef struct packed {
    logic     valid;
    rob_tag_t rob_tag;
    word      result;
  } complete_stage_struct;

endpackage

`default_nettype wire

// File: rtl/rob_retire_select.sv
// ============================================================================
// rob_retire_select : in-order retire slot enables and retire count
// Revision: 1.0
// ============================================================================
`default_nettype none

module rob_retire_select
  import complete_stage_pkg::*;
(
  input  logic                 ready_i      [0:DISPATCH_W-1],
  output logic                 slot_en_o    [0:DISPATCH_W-1],
  output logic [RET_CNT_W-1:0] retire_cnt_o
);

  logic w_chain;

  // A younger slot may only retire when every older slot retires too.
  always_comb begin
    w_chain      = 1'b1;
    retire_cnt_o = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      w_chain      = w_chain & ready_i[k];
      slot_en_o[k] = w_chain;
      if (w_chain) begin
        retire_cnt_o = retire_cnt_o + RET_CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/complete_stage.sv
// ============================================================================
// complete_stage : 16-entry reorder buffer with completion broadcast and
//                  2-wide in-order retirement.
// Option: COMPLETE_RETIRE_BYPASS_EN lets a row retire on its completion edge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module complete_stage
  import complete_stage_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  rob_row_struct        i_rob_row           [0:DISPATCH_W-1],
  input  complete_stage_struct i_complete_result   [0:NUM_FU-1],
  output rob_row_struct        o_complete_rob_rows [0:NUM_FU-1],
  output rob_row_struct        o_retire_rob_rows   [0:DISPATCH_W-1],
  output logic                 o_fu_ready          [0:NUM_FU-1],
  output logic                 o_rob_full
);

  rob_row_struct rob_q      [0:ROB_DEPTH-1];
  rob_row_struct rob_d      [0:ROB_DEPTH-1];
  rob_row_struct rob_view   [0:ROB_DEPTH-1];
  rob_tag_t      head_q, head_d;
  rob_cnt_t      count_q, count_d;
  rob_row_struct cmp_rows_q [0:NUM_FU-1];
  rob_row_struct cmp_rows_d [0:NUM_FU-1];
  rob_row_struct ret_rows_q [0:DISPATCH_W-1];
  rob_row_struct ret_rows_d [0:DISPATCH_W-1];
  logic          fu_ready_q [0:NUM_FU-1];
  logic          fu_ready_d [0:NUM_FU-1];

  logic                 w_hit     [0:NUM_FU-1];
  rob_tag_t             w_ret_idx [0:DISPATCH_W-1];
  logic                 w_ready   [0:DISPATCH_W-1];
  logic                 w_slot_en [0:DISPATCH_W-1];
  logic [RET_CNT_W-1:0] w_ret_cnt;
  rob_cnt_t             w_alloc_cnt;

  // Completion view: ROB contents with this cycle's FU results applied.
  always_comb begin
    rob_view   = rob_q;
    cmp_rows_d = '{default: '0};
    for (int f = 0; f < NUM_FU; f++) begin
      fu_ready_d[f] = i_complete_result[f].valid;
      w_hit[f]      = i_complete_result[f].valid
                      && rob_q[i_complete_result[f].rob_tag].valid
                      && !rob_q[i_complete_result[f].rob_tag].complete;
      for (int g = 0; g < f; g++) begin
        if (i_complete_result[g].valid
            && (i_complete_result[g].rob_tag == i_complete_result[f].rob_tag)) begin
          w_hit[f] = 1'b0;
        end
      end
      if (w_hit[f]) begin
        rob_view[i_complete_result[f].rob_tag].complete = 1'b1;
        rob_view[i_complete_result[f].rob_tag].data     = i_complete_result[f].result;
        cmp_rows_d[f] = rob_view[i_complete_result[f].rob_tag];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < DISPATCH_W; k++) begin
      w_ret_idx[k] = head_q + rob_tag_t'(k);
`ifdef COMPLETE_RETIRE_BYPASS_EN
      w_ready[k]   = rob_view[w_ret_idx[k]].valid && rob_view[w_ret_idx[k]].complete;
`else
      w_ready[k]   = rob_q[w_ret_idx[k]].valid && rob_q[w_ret_idx[k]].complete;
`endif
    end
  end

  rob_retire_select u_retire_select (
    .ready_i      (w_ready),
    .slot_en_o    (w_slot_en),
    .retire_cnt_o (w_ret_cnt)
  );

  // Allocation checks pre-edge validity, so a slot freed this cycle stays busy.
  always_comb begin
    rob_d       = rob_view;
    ret_rows_d  = '{default: '0};
    w_alloc_cnt = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      if (w_slot_en[k]) begin
        ret_rows_d[k]       = rob_view[w_ret_idx[k]];
        rob_d[w_ret_idx[k]] = '0;
      end
    end
    for (int k = 0; k < DISPATCH_W; k++) begin
      if (i_rob_row[k].valid && !rob_q[i_rob_row[k].rob_tag].valid) begin
        rob_d[i_rob_row[k].rob_tag]          = i_rob_row[k];
        rob_d[i_rob_row[k].rob_tag].complete = 1'b0;
        w_alloc_cnt = w_alloc_cnt + rob_cnt_t'(1);
      end
    end
    head_d  = head_q + rob_tag_t'(w_ret_cnt);
    count_d = count_q + w_alloc_cnt - rob_cnt_t'(w_ret_cnt);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rob_q      <= '{default: '0};
      head_q     <= '0;
      count_q    <= '0;
      cmp_rows_q <= '{default: '0};
      ret_rows_q <= '{default: '0};
      fu_ready_q <= '{default: 1'b0};
    end else begin
      rob_q      <= rob_d;
      head_q     <= head_d;
      count_q    <= count_d;
      cmp_rows_q <= cmp_rows_d;
      ret_rows_q <= ret_rows_d;
      fu_ready_q <= fu_ready_d;
    end
  end

  assign o_complete_rob_rows = cmp_rows_q;
  assign o_retire_rob_rows   = ret_rows_q;
  assign o_fu_ready          = fu_ready_q;
  assign o_rob_full          = (ROB_DEPTH - int'(count_q)) < DISPATCH_W;

endmodule

`default_nettype wire

// File: tb/tb_complete_stage.sv
// ============================================================================
// tb_complete_stage : self-checking bench for complete_stage
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_complete_stage;
  import complete_stage_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  rob_row_struct        rob_row  [0:DISPATCH_W-1];
  complete_stage_struct cres     [0:NUM_FU-1];
  rob_row_struct        cmp_rows [0:NUM_FU-1];
  rob_row_struct        ret_rows [0:DISPATCH_W-1];
  logic                 fu_ready [0:NUM_FU-1];
  logic                 rob_full;

  int n_checks = 0;
  int n_fail   = 0;

  rob_row_struct exp_ret [$];
  rob_row_struct got_ret [$];
  rob_row_struct exp_cmp [$];
  int            exp_fu  [$];

  always #5 clk = ~clk;

  complete_stage dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_rob_row           (rob_row),
    .i_complete_result   (cres),
    .o_complete_rob_rows (cmp_rows),
    .o_retire_rob_rows   (ret_rows),
    .o_fu_ready          (fu_ready),
    .o_rob_full          (rob_full)
  );

  function automatic rob_row_struct mk_row(input int tag, input int preg, input word data,
                                           input logic regw, input logic memw);
    rob_row_struct r;
    r.valid       = 1'b1;
    r.rob_tag     = rob_tag_t'(tag);
    r.PRegAddrDst = p_reg'(preg);
    r.data        = data;
    r.RegWrite    = regw;
    r.MemWrite    = memw;
    r.complete    = 1'b1;
    return r;
  endfunction

  task automatic idle_inputs();
    for (int k = 0; k < DISPATCH_W; k++) rob_row[k] = '0;
    for (int f = 0; f < NUM_FU; f++) cres[f] = '0;
  endtask

  task automatic dispatch(input int slot, input int tag, input int preg, input word data,
                          input logic regw, input logic memw);
    rob_row[slot]          = mk_row(tag, preg, data, regw, memw);
    rob_row[slot].complete = 1'b0;
  endtask

  task automatic result(input int fu, input int tag, input word val);
    cres[fu].valid   = 1'b1;
    cres[fu].rob_tag = rob_tag_t'(tag);
    cres[fu].result  = val;
  endtask

  // Advance one edge and record every retired row seen afterwards.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < DISPATCH_W; k++)
      if (ret_rows[k].valid) got_ret.push_back(ret_rows[k]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    got_ret.delete();
    exp_ret.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dispatch(0, 0, 1, 32'h1, 1'b1, 1'b0);
    result(0, 0, 32'h5);
    result(2, 3, 32'h6);
    step();
    step();
    for (int f = 0; f < NUM_FU; f++) begin
      n_checks++;
      if (cmp_rows[f] !== '0) begin
        n_fail++; $display("FAIL reset_cmp_row%0d: got %h expected 0", f, cmp_rows[f]);
      end
      n_checks++;
      if (fu_ready[f] !== 1'b0) begin
        n_fail++; $display("FAIL reset_fu_ready%0d: got %b expected 0", f, fu_ready[f]);
      end
    end
    for (int k = 0; k < DISPATCH_W; k++) begin
      n_checks++;
      if (ret_rows[k] !== '0) begin
        n_fail++; $display("FAIL reset_ret_row%0d: got %h expected 0", k, ret_rows[k]);
      end
    end
    n_checks++;
    if (rob_full !== 1'b0) begin
      n_fail++; $display("FAIL reset_rob_full: got %b expected 0", rob_full);
    end
    rst = 1'b0;
    idle_inputs();
    got_ret.delete();
  endtask

  task automatic test_basic();
    logic [2:0] fr;
    do_reset();
    dispatch(0, 0, 5, 32'h0, 1'b1, 1'b0);
    dispatch(1, 1, 6, 32'h0, 1'b1, 1'b0);
    step();
    idle_inputs();
    result(0, 0, 32'h11);
    result(2, 1, 32'h22);
    step();
    idle_inputs();
    n_checks++;
    if (cmp_rows[0] !== mk_row(0, 5, 32'h11, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL basic_cmp0: got %h expected %h", cmp_rows[0], mk_row(0, 5, 32'h11, 1'b1, 1'b0));
    end
    n_checks++;
    if (cmp_rows[1].valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_cmp1_valid: got %b expected 0", cmp_rows[1].valid);
    end
    n_checks++;
    if (cmp_rows[2] !== mk_row(1, 6, 32'h22, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL basic_cmp2: got %h expected %h", cmp_rows[2], mk_row(1, 6, 32'h22, 1'b1, 1'b0));
    end
    fr = {fu_ready[0], fu_ready[1], fu_ready[2]};
    n_checks++;
    if (fr !== 3'b101) begin
      n_fail++; $display("FAIL basic_fu_ready: got %b expected 101", fr);
    end
`ifndef COMPLETE_RETIRE_BYPASS_EN
    n_checks++;
    if (ret_rows[0].valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_early_retire: got %b expected 0", ret_rows[0].valid);
    end
    step();
`endif
    n_checks++;
    if (ret_rows[0] !== mk_row(0, 5, 32'h11, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL basic_ret0: got %h expected %h", ret_rows[0], mk_row(0, 5, 32'h11, 1'b1, 1'b0));
    end
    n_checks++;
    if (ret_rows[1] !== mk_row(1, 6, 32'h22, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL basic_ret1: got %h expected %h", ret_rows[1], mk_row(1, 6, 32'h22, 1'b1, 1'b0));
    end
    step();
    fr = {fu_ready[0], fu_ready[1], fu_ready[2]};
    n_checks++;
    if (fr !== 3'b000) begin
      n_fail++; $display("FAIL basic_fu_ready_clear: got %b expected 000", fr);
    end
    got_ret.delete();
  endtask

  task automatic test_out_of_order();
    do_reset();
    dispatch(0, 0, 7, 32'h0, 1'b1, 1'b0);
    dispatch(1, 1, 8, 32'h0, 1'b1, 1'b0);
    rob_row[0].complete = 1'b1;
    rob_row[1].complete = 1'b1;
    step();
    idle_inputs();
    result(1, 1, 32'hB1);
    step();
    idle_inputs();
    step();
    step();
    n_checks++;
    if (got_ret.size() != 0) begin
      n_fail++; $display("FAIL ooo_no_retire: got %0d rows expected 0", got_ret.size());
    end
    result(0, 0, 32'hA0);
    step();
    idle_inputs();
`ifndef COMPLETE_RETIRE_BYPASS_EN
    n_checks++;
    if (ret_rows[0].valid !== 1'b0) begin
      n_fail++; $display("FAIL ooo_early_retire: got %b expected 0", ret_rows[0].valid);
    end
    step();
`endif
    n_checks++;
    if (ret_rows[0] !== mk_row(0, 7, 32'hA0, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL ooo_ret0: got %h expected %h", ret_rows[0], mk_row(0, 7, 32'hA0, 1'b1, 1'b0));
    end
    n_checks++;
    if (ret_rows[1] !== mk_row(1, 8, 32'hB1, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL ooo_ret1: got %h expected %h", ret_rows[1], mk_row(1, 8, 32'hB1, 1'b1, 1'b0));
    end
    step();
    got_ret.delete();
  endtask

  task automatic test_same_tag();
    logic [2:0] fr;
    do_reset();
    dispatch(0, 0, 9, 32'h0, 1'b1, 1'b0);
    exp_ret.push_back(mk_row(0, 9, 32'hA, 1'b1, 1'b0));
    step();
    idle_inputs();
    result(0, 7, 32'hEE);
    result(1, 0, 32'hA);
    result(2, 0, 32'hB);
    step();
    idle_inputs();
    n_checks++;
    if (cmp_rows[0].valid !== 1'b0) begin
      n_fail++; $display("FAIL same_tag_invalid_hit: got %b expected 0", cmp_rows[0].valid);
    end
    n_checks++;
    if (cmp_rows[1] !== mk_row(0, 9, 32'hA, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL same_tag_low_wins: got %h expected %h", cmp_rows[1], mk_row(0, 9, 32'hA, 1'b1, 1'b0));
    end
    n_checks++;
    if (cmp_rows[2].valid !== 1'b0) begin
      n_fail++; $display("FAIL same_tag_high_loses: got %b expected 0", cmp_rows[2].valid);
    end
    fr = {fu_ready[0], fu_ready[1], fu_ready[2]};
    n_checks++;
    if (fr !== 3'b111) begin
      n_fail++; $display("FAIL same_tag_fu_ready: got %b expected 111", fr);
    end
    result(0, 0, 32'hC);
    step();
    idle_inputs();
    n_checks++;
    if (cmp_rows[0].valid !== 1'b0) begin
      n_fail++; $display("FAIL same_tag_recomplete: got %b expected 0", cmp_rows[0].valid);
    end
    fr = {fu_ready[0], fu_ready[1], fu_ready[2]};
    n_checks++;
    if (fr !== 3'b100) begin
      n_fail++; $display("FAIL same_tag_fu_ready2: got %b expected 100", fr);
    end
    step();
    step();
    n_checks++;
    if (got_ret.size() != exp_ret.size()) begin
      n_fail++; $display("FAIL same_tag_ret_count: got %0d expected %0d", got_ret.size(), exp_ret.size());
    end else begin
      while (exp_ret.size() > 0) begin
        rob_row_struct e, g;
        e = exp_ret.pop_front();
        g = got_ret.pop_front();
        n_checks++;
        if (g !== e) begin
          n_fail++; $display("FAIL same_tag_ret_row: got %h expected %h", g, e);
        end
      end
    end
    got_ret.delete();
    exp_ret.delete();
  endtask

  task automatic test_wrap();
    do_reset();
    exp_cmp.delete();
    exp_fu.delete();
    for (int i = 0; i < 22; i++) begin
      idle_inputs();
      if (i < 20) begin
        dispatch(0, i % 16, 20 + i, 32'h0, 1'b1, 1'b0);
        exp_ret.push_back(mk_row(i % 16, 20 + i, 32'h100 + i, 1'b1, 1'b0));
      end
      if (i >= 1 && i <= 20) begin
        result((i - 1) % 3, (i - 1) % 16, 32'h100 + i - 1);
        exp_cmp.push_back(mk_row((i - 1) % 16, 20 + i - 1, 32'h100 + i - 1, 1'b1, 1'b0));
        exp_fu.push_back((i - 1) % 3);
      end
      step();
      while (exp_cmp.size() > 0) begin
        rob_row_struct e;
        int fu;
        e  = exp_cmp.pop_front();
        fu = exp_fu.pop_front();
        n_checks++;
        if (cmp_rows[fu] !== e) begin
          n_fail++; $display("FAIL wrap_cmp_fu%0d: got %h expected %h", fu, cmp_rows[fu], e);
        end
      end
    end
    idle_inputs();
    repeat (4) step();
    n_checks++;
    if (got_ret.size() != exp_ret.size()) begin
      n_fail++; $display("FAIL wrap_ret_count: got %0d expected %0d", got_ret.size(), exp_ret.size());
    end else begin
      while (exp_ret.size() > 0) begin
        rob_row_struct e, g;
        e = exp_ret.pop_front();
        g = got_ret.pop_front();
        n_checks++;
        if (g !== e) begin
          n_fail++; $display("FAIL wrap_ret_order: got %h expected %h", g, e);
        end
      end
    end
    n_checks++;
    if (rob_full !== 1'b0) begin
      n_fail++; $display("FAIL wrap_rob_full: got %b expected 0", rob_full);
    end
    got_ret.delete();
    exp_ret.delete();
  endtask

  task automatic test_full();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      dispatch(0, 2 * c,     10 + 2 * c, 32'hA0 + 2 * c, 1'b1, 1'b0);
      dispatch(1, 2 * c + 1, 11 + 2 * c, 32'hA1 + 2 * c, 1'b1, 1'b0);
      step();
      if (c == 6) begin
        n_checks++;
        if (rob_full !== 1'b0) begin
          n_fail++; $display("FAIL full_at_14: got %b expected 0", rob_full);
        end
      end
    end
    n_checks++;
    if (rob_full !== 1'b1) begin
      n_fail++; $display("FAIL full_at_16: got %b expected 1", rob_full);
    end
    idle_inputs();
    dispatch(0, 0, 99, 32'hDEAD, 1'b1, 1'b0);
    step();
    idle_inputs();
    n_checks++;
    if (rob_full !== 1'b1) begin
      n_fail++; $display("FAIL full_after_drop: got %b expected 1", rob_full);
    end
    result(1, 0, 32'h55);
    exp_ret.push_back(mk_row(0, 10, 32'h55, 1'b1, 1'b0));
    step();
    idle_inputs();
    n_checks++;
    if (cmp_rows[1] !== mk_row(0, 10, 32'h55, 1'b1, 1'b0)) begin
      n_fail++; $display("FAIL full_kept_entry: got %h expected %h", cmp_rows[1], mk_row(0, 10, 32'h55, 1'b1, 1'b0));
    end
    result(0, 1, 32'h66);
    exp_ret.push_back(mk_row(1, 11, 32'h66, 1'b1, 1'b0));
    step();
    idle_inputs();
    repeat (3) step();
    n_checks++;
    if (rob_full !== 1'b0) begin
      n_fail++; $display("FAIL full_after_retire: got %b expected 0", rob_full);
    end
    n_checks++;
    if (got_ret.size() != exp_ret.size()) begin
      n_fail++; $display("FAIL full_ret_count: got %0d expected %0d", got_ret.size(), exp_ret.size());
    end else begin
      while (exp_ret.size() > 0) begin
        rob_row_struct e, g;
        e = exp_ret.pop_front();
        g = got_ret.pop_front();
        n_checks++;
        if (g !== e) begin
          n_fail++; $display("FAIL full_ret_row: got %h expected %h", g, e);
        end
      end
    end
    got_ret.delete();
    exp_ret.delete();
  endtask

  task automatic test_store();
    rob_row_struct e;
    do_reset();
    dispatch(0, 0, 1, 32'h0, 1'b1, 1'b0);
    dispatch(1, 1, 2, 32'h0, 1'b1, 1'b0);
    step();
    idle_inputs();
    dispatch(0, 2, 3, 32'h0, 1'b1, 1'b0);
    dispatch(1, 3, 0, 32'h0, 1'b0, 1'b1);
    result(0, 0, 32'h10);
    result(1, 1, 32'h20);
    step();
    idle_inputs();
    result(2, 2, 32'h30);
    step();
    idle_inputs();
    step();
    step();
    n_checks++;
    if (got_ret.size() != 3) begin
      n_fail++; $display("FAIL store_prior_retires: got %0d expected 3", got_ret.size());
    end
    got_ret.delete();
    e = mk_row(3, 0, 32'h1000, 1'b0, 1'b1);
    result(0, 3, 32'h1000);
    step();
    idle_inputs();
    n_checks++;
    if (cmp_rows[0] !== e) begin
      n_fail++; $display("FAIL store_cmp: got %h expected %h", cmp_rows[0], e);
    end
`ifndef COMPLETE_RETIRE_BYPASS_EN
    n_checks++;
    if (ret_rows[0].valid !== 1'b0) begin
      n_fail++; $display("FAIL store_early_retire: got %b expected 0", ret_rows[0].valid);
    end
    step();
`endif
    n_checks++;
    if (ret_rows[0] !== e) begin
      n_fail++; $display("FAIL store_ret: got %h expected %h", ret_rows[0], e);
    end
    step();
    got_ret.delete();
  endtask

  task automatic test_mid_reset();
    logic [2:0] fr;
    do_reset();
    dispatch(0, 0, 4, 32'h0, 1'b1, 1'b0);
    dispatch(1, 1, 5, 32'h0, 1'b1, 1'b0);
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    result(0, 0, 32'h77);
    result(1, 1, 32'h88);
    step();
    idle_inputs();
    n_checks++;
    if (cmp_rows[0].valid !== 1'b0 || cmp_rows[1].valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_cmp: got %b%b expected 00", cmp_rows[0].valid, cmp_rows[1].valid);
    end
    fr = {fu_ready[0], fu_ready[1], fu_ready[2]};
    n_checks++;
    if (fr !== 3'b110) begin
      n_fail++; $display("FAIL mid_reset_fu_ready: got %b expected 110", fr);
    end
    step();
    step();
    n_checks++;
    if (got_ret.size() != 0) begin
      n_fail++; $display("FAIL mid_reset_retire: got %0d rows expected 0", got_ret.size());
    end
    got_ret.delete();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_basic();
    test_out_of_order();
    test_same_tag();
    test_wrap();
    test_full();
    test_store();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/complete_stage.md
Name: complete_stage

Overview:
- Completion/retirement stage of the 2-wide out-of-order RISC-V core (module COMPLETE): a 16-entry circular reorder buffer (ROB).
- Accepts up to 2 dispatched ROB rows per cycle from DISPATCH and up to 3 functional-unit results from ISSUE.
- Broadcasts completed rows back to RENAME/DISPATCH for wakeup, pulses per-FU free flags, and retires up to 2 rows per cycle in program order to the register-file/memory write logic.

Parameters:
- ROB_DEPTH, 16, ROB entries (power of 2); tag width = log2(ROB_DEPTH).
- DISPATCH_W, 2, dispatched rows accepted per cycle and retire width.
- NUM_FU, 3, functional units / result ports.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_rob_row  input  rob_row_struct[0:DISPATCH_W-1]  newly dispatched rows; fields: valid, rob_tag, PRegAddrDst, data, RegWrite, MemWrite, complete.
- i_complete_result  input  complete_stage_struct[0:NUM_FU-1]  FU results; fields: valid, rob_tag, result (32b word).
- o_complete_rob_rows  output  rob_row_struct[0:NUM_FU-1]  rows completed last cycle, indexed by FU.
- o_retire_rob_rows  output  rob_row_struct[0:DISPATCH_W-1]  rows retired last cycle; [0] is older.
- o_fu_ready  output  1[0:NUM_FU-1]  FU f freed.
- o_rob_full  output  1  fewer than DISPATCH_W free entries.

Behaviour:
- Reset: all entries valid=0 and complete=0; head=0, count=0; every output row valid=0 with fields 0; o_fu_ready all 0; o_rob_full 0.
- Allocation:
  - Each valid i_rob_row[k] writes entry[rob_tag] with complete=0.
  - DISPATCH assigns tags sequentially modulo ROB_DEPTH; [0] precedes [1].
  - A write to an entry already valid is dropped (no overwrite).
  - count += number of accepted rows.
- Completion:
  - For each valid i_complete_result[f] whose tag hits an entry with valid=1 and complete=0: set complete=1 and data <= result.
  - For MemWrite rows, result is the store address.
  - Next cycle, o_complete_rob_rows[f] = updated entry with valid=1; otherwise valid=0.
  - Results to invalid or already-complete entries are ignored and produce no output.
- o_fu_ready[f]: 1 for exactly the cycle after any valid result on port f, regardless of whether the tag hit; else 0.
- Retirement uses pre-edge state, so rows completed or allocated at edge N retire no earlier than edge N+1:
  - Slot 0 retires entry[head] if valid and complete.
  - Slot 1 retires entry[head+1] only if slot 0 retired and entry[head+1] is valid and complete.
  - Retired entries are cleared (valid=0); head advances by the number retired, wrapping modulo ROB_DEPTH.
  - count -= number retired.
  - o_retire_rob_rows is registered (1-cycle latency) and carries the full row; unused slots have valid=0.
- Simultaneous events:
  - Allocation into an entry freed by retirement in the same cycle is rejected: the entry is still valid pre-edge.
  - Completion and retirement of different entries in the same cycle are independent.
  - Two result ports naming the same tag: the lower FU index wins; the higher port still pulses o_fu_ready.
- o_rob_full = (ROB_DEPTH - count) < DISPATCH_W, computed from registered count.
- Reset asserted mid-operation discards all in-flight entries within one edge.

Optional Feature:
- Macro COMPLETE_RETIRE_BYPASS_EN.
- Defined: the retire logic also treats an entry as complete if a valid result hits it in the current cycle. That entry retires at the same edge it completes; its retire row carries the new data, and it still appears on o_complete_rob_rows.
- Undefined: the retire logic uses pre-edge state only, so completion-to-retire latency is at least one extra cycle.

Decomposition:
- Package Types holds:
  - word (32b) and p_reg (7b);
  - rob_tag_t;
  - rob_row_struct and complete_stage_struct;
  - constants ROB_DEPTH, DISPATCH_W, NUM_FU.
- One natural sub-module, rob_retire_select: combinational head / head+1 readiness check producing retire count and slot enables.

Test Plan:
- Reset: assert i_rst 2 cycles → all outputs valid=0, o_fu_ready=000, o_rob_full=0.
- Dispatch tags 0,1 (RegWrite, PRegAddrDst 5,6); results FU0 tag0=0x11, FU2 tag1=0x22 → next cycle o_complete_rob_rows[0].data=0x11, [2].data=0x22, o_fu_ready=101; following cycle both retire: slot0 PReg5/0x11, slot1 PReg6/0x22.
- Out-of-order completion: tags 0,1 dispatched; tag1 completes first → no retire until tag0 completes, then both retire in the same cycle in order 0,1.
- Wrap: push 20 rows, completing and retiring continuously → tags 15 then 0 retire in order; head wraps to 0; no row is lost.
- Full: dispatch 16 rows, none completed → o_rob_full=1; a further dispatch of tag 0 is dropped and entry 0 keeps its original data.
- Store: MemWrite row tag3 gets result 0x1000 → retire row has MemWrite=1, data=0x1000. With COMPLETE_RETIRE_BYPASS_EN, if tag3 is at head it retires at the same edge it completes.
